// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared definitions for the UART FIFO front end: register map, status/control
// bit positions and the TX issue state encoding.
package uart_fifo_ctrl_pkg;

  localparam logic [3:0] UART_DATA_OFS   = 4'h0;
  localparam logic [3:0] UART_STATUS_OFS = 4'h4;
  localparam logic [3:0] UART_CTRL_OFS   = 4'h8;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_RX_OVR     = 4;
  localparam int ST_TX_OVF     = 5;
  localparam int ST_RX_CNT_LSB = 8;
  localparam int ST_TX_CNT_LSB = 16;

  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;
  localparam int CTRL_FLUSH     = 2;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_ISSUE = 2'd1,
    T_WAIT  = 2'd2
  } tx_state_e;

  function automatic logic [31:0] pack_status(
    input logic       tx_full,
    input logic       tx_empty,
    input logic       rx_empty,
    input logic       rx_full,
    input logic       rx_ovr,
    input logic       tx_ovf,
    input logic [7:0] rx_count,
    input logic [7:0] tx_count
  );
    logic [31:0] s;
    s                        = '0;
    s[ST_TX_FULL]            = tx_full;
    s[ST_TX_EMPTY]           = tx_empty;
    s[ST_RX_EMPTY]           = rx_empty;
    s[ST_RX_FULL]            = rx_full;
    s[ST_RX_OVR]             = rx_ovr;
    s[ST_TX_OVF]             = tx_ovf;
    s[ST_RX_CNT_LSB +: 8]    = rx_count;
    s[ST_TX_CNT_LSB +: 8]    = tx_count;
    return s;
  endfunction

endpackage

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// Single-clock FIFO with flush; the head entry is visible without a read
// strobe so the consumer can sample it in the same cycle it pops.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             pop_ok;
  logic             push_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o && !flush_i;
  // A full FIFO still accepts a push when an entry leaves in the same cycle.
  assign push_ok = push_i && !flush_i && (!full_o || pop_ok);
  assign ovf_o   = push_i && !flush_i && !push_ok;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Memory-mapped UART front end: TX FIFO feeding the transmitter through a
// tx_en/tx_busy handshake, RX FIFO capturing received bytes, status and irq.
module uart_fifo_ctrl
  import uart_fifo_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  addr_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        tx_busy_i,
  output logic        tx_en_o,
  output logic [7:0]  tx_data_o,
  input  logic        rx_ready_i,
  input  logic [7:0]  rx_data_i,
  output logic        irq_o
);

  tx_state_e        state_q, state_d;
  logic             seen_busy_q, seen_busy_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             rx_ovr_q, rx_ovr_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic             rx_ready_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  logic             wr_data, rd_data, rd_status, wr_ctrl, flush;
  logic             rx_rise;
  logic [7:0]       tx_head, rx_head;
  logic [FIFO_AW:0] tx_count, rx_count;
  logic             tx_full, tx_empty, tx_ovf_ev;
  logic             rx_full, rx_empty, rx_ovr_ev;
  logic             unused_wdata;

  assign unused_wdata = ^wdata_i[31:8];

  assign wr_data   = we_i && (addr_i == UART_DATA_OFS);
  assign rd_data   = re_i && (addr_i == UART_DATA_OFS);
  assign rd_status = re_i && (addr_i == UART_STATUS_OFS);
  assign wr_ctrl   = we_i && (addr_i == UART_CTRL_OFS);
  assign flush     = wr_ctrl && wdata_i[CTRL_FLUSH];
  assign rx_rise   = rx_ready_i && !rx_ready_q;
  assign tx_en_o   = (state_q == T_ISSUE);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (wr_data),
    .din_i   (wdata_i[7:0]),
    .pop_i   (tx_en_o),
    .head_o  (tx_head),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .ovf_o   (tx_ovf_ev)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (rx_rise),
    .din_i   (rx_data_i),
    .pop_i   (rd_data),
    .head_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .ovf_o   (rx_ovr_ev)
  );

  // Issue FSM; WAIT only exits after busy has been seen high and then low.
  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    tx_data_d   = tx_data_q;
    case (state_q)
      T_IDLE: begin
        if (!tx_empty && !tx_busy_i) begin
          state_d   = T_ISSUE;
          tx_data_d = tx_head;
        end
      end
      T_ISSUE: begin
        state_d     = T_WAIT;
        seen_busy_d = 1'b0;
      end
      T_WAIT: begin
        if (tx_busy_i) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          state_d = T_IDLE;
        end
      end
      default: state_d = T_IDLE;
    endcase
    if (flush) begin
      state_d     = T_IDLE;
      seen_busy_d = 1'b0;
      tx_data_d   = tx_data_q;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      case (addr_i)
        UART_DATA_OFS:   rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
        UART_STATUS_OFS: rdata_d = pack_status(tx_full, tx_empty, rx_empty, rx_full,
                                               rx_ovr_q, tx_ovf_q, 8'(rx_count), 8'(tx_count));
        UART_CTRL_OFS:   rdata_d = {30'h0, ctrl_q};
        default:         rdata_d = 32'h0;
      endcase
    end
    ctrl_d   = wr_ctrl ? wdata_i[1:0] : ctrl_q;
    // A new error event in the same cycle as a STATUS read keeps the flag set.
    rx_ovr_d = flush ? 1'b0 : ((rx_ovr_q && !rd_status) || rx_ovr_ev);
    tx_ovf_d = flush ? 1'b0 : ((tx_ovf_q && !rd_status) || tx_ovf_ev);
    irq_d    = (ctrl_q[CTRL_RX_IRQ_EN] && !rx_empty) ||
               (ctrl_q[CTRL_TX_IRQ_EN] && tx_empty && (state_q == T_IDLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= T_IDLE;
      seen_busy_q <= 1'b0;
      tx_data_q   <= '0;
      ctrl_q      <= '0;
      rx_ovr_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      rx_ready_q  <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
      tx_data_q   <= tx_data_d;
      ctrl_q      <= ctrl_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ready_q  <= rx_ready_i;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign tx_data_o = tx_data_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: a queue-based model predicts read data,
// issued TX bytes and irq; a negedge monitor pops and compares.
module tb_uart_fifo_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  addr_i = '0;
  logic        we_i = 1'b0;
  logic        re_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        tx_busy_i = 1'b0;
  logic        tx_en_o;
  logic [7:0]  tx_data_o;
  logic        rx_ready_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        irq_o;

  always #5 clk = ~clk;

  uart_fifo_ctrl #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (addr_i),
    .we_i       (we_i),
    .re_i       (re_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .tx_busy_i  (tx_busy_i),
    .tx_en_o    (tx_en_o),
    .tx_data_o  (tx_data_o),
    .rx_ready_i (rx_ready_i),
    .rx_data_i  (rx_data_i),
    .irq_o      (irq_o)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  logic        m_rx_ovr = 1'b0, m_tx_ovf = 1'b0, m_rx_prev = 1'b0;
  logic [1:0]  m_ctrl = '0;
  // scoreboard queues
  logic [31:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] last_rd = '0;
  logic        rd_due = 1'b0;
  logic        irq_cur = 1'b0, irq_next = 1'b0;
  logic        irq_known_cur = 1'b1, irq_known_next = 1'b1;
  logic        mon_on = 1'b0;
  logic [31:0] mon_e;
  // transmitter and receiver stimulus state
  int          busy_cnt = 0, busy_min = 1, busy_max = 10, quiet_cnt = 0, rx_hold = 0;
  logic        hold_busy = 1'b0, en_prev = 1'b0;
  logic        rx_lvl = 1'b0;
  logic [7:0]  rx_byte = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {8'h0, 8'(m_tx.size()), 8'(m_rx.size()), 2'b0, m_tx_ovf, m_rx_ovr,
            m_rx.size() == DEPTH, m_rx.size() == 0, m_tx.size() == 0, m_tx.size() == DEPTH};
  endfunction

  // One bus cycle: drive inputs, then advance the model by what this cycle does.
  task automatic step(input logic we, input logic re, input logic [3:0] addr, input logic [31:0] wd);
    logic        en_now, rx_push, flush, rx_pop, clr, set_r, set_t;
    logic [31:0] rexp;
    @(posedge clk);
    #1;
    irq_cur       = irq_next;
    irq_known_cur = irq_known_next;
    if (en_prev) busy_cnt = int'($urandom_range(busy_min, busy_max));
    tx_busy_i = hold_busy || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    we_i = we; re_i = re; addr_i = addr; wdata_i = wd;
    rx_ready_i = rx_lvl; rx_data_i = rx_byte;
    en_now = tx_en_o;
    if (tx_busy_i || en_now) quiet_cnt = 0; else quiet_cnt++;
    irq_next       = (m_ctrl[0] && m_rx.size() != 0) ||
                     (m_ctrl[1] && m_tx.size() == 0 && quiet_cnt >= 3);
    irq_known_next = !(m_ctrl[1] && m_tx.size() == 0 && quiet_cnt < 3);
    clr = 1'b0; rx_pop = 1'b0; set_r = 1'b0; set_t = 1'b0; rexp = '0;
    if (re) begin
      case (addr)
        4'h0: if (m_rx.size() != 0) begin rexp = {24'h0, m_rx[0]}; rx_pop = 1'b1; end
        4'h4: begin rexp = model_status(); clr = 1'b1; end
        4'h8: rexp = {30'h0, m_ctrl};
        default: rexp = '0;
      endcase
      exp_rd.push_back(rexp);
    end
    rx_push   = rx_lvl && !m_rx_prev;
    m_rx_prev = rx_lvl;
    flush     = we && (addr == 4'h8) && wd[2];
    if (en_now && m_tx.size() != 0) exp_tx.push_back(m_tx.pop_front());
    if (flush) begin
      m_tx.delete(); m_rx.delete();
      m_rx_ovr = 1'b0; m_tx_ovf = 1'b0; m_ctrl = wd[1:0];
    end else begin
      if (rx_pop) void'(m_rx.pop_front());
      if (rx_push) begin
        if (m_rx.size() < DEPTH) m_rx.push_back(rx_byte); else set_r = 1'b1;
      end
      if (we && addr == 4'h0) begin
        if (m_tx.size() < DEPTH) m_tx.push_back(wd[7:0]); else set_t = 1'b1;
      end
      m_rx_ovr = (m_rx_ovr && !clr) || set_r;
      m_tx_ovf = (m_tx_ovf && !clr) || set_t;
      if (we && addr == 4'h8) m_ctrl = wd[1:0];
    end
    en_prev = en_now;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    @(posedge clk);
    #3;
    we_i = 1'b0; re_i = 1'b0; rx_lvl = 1'b0; rx_ready_i = 1'b0; rx_hold = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_tx_en", 32'(tx_en_o), 32'h0);
    chk("rst_tx_data", 32'(tx_data_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    m_tx.delete(); m_rx.delete(); exp_rd.delete(); exp_tx.delete();
    m_rx_ovr = 1'b0; m_tx_ovf = 1'b0; m_rx_prev = 1'b0; m_ctrl = '0;
    last_rd = '0; rd_due = 1'b0; irq_cur = 1'b0; irq_next = 1'b0;
    irq_known_cur = 1'b1; irq_known_next = 1'b1; en_prev = 1'b0; quiet_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic rand_phase(input int n, input int rd_pct);
    int r;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      if (rx_hold > 0) rx_hold--;
      else if (rx_lvl) rx_lvl = 1'b0;
      else if ($urandom_range(0, 3) == 0) begin
        rx_lvl = 1'b1; rx_byte = 8'($urandom); rx_hold = int'($urandom_range(0, 3));
      end
      r = int'($urandom_range(0, 99));
      d = $urandom;
      if (r < 30) wr(4'h0, d);
      else if (r < 30 + rd_pct) rd(4'h0);
      else if (r < 40 + rd_pct) rd(4'h4);
      else if (r < 43 + rd_pct) wr(4'h8, {29'h0, ($urandom_range(0, 9) == 0), d[1:0]});
      else if (r < 45 + rd_pct) rd(4'h8);
      else if (r < 47 + rd_pct) step(d[0], d[1], 4'hC, d);
      else if (r < 50 + rd_pct) step(1'b1, 1'b1, 4'h0, d);
      else idle(1);
    end
    rx_lvl = 1'b0; rx_hold = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_tx.size() != 0 || busy_cnt != 0 || hold_busy) && n < 3000) begin
      idle(1);
      n++;
    end
    chk("tx_drain", 32'(m_tx.size()), 32'h0);
    idle(5);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (rd_due) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata_extra: got %h expected none", rdata_o);
        end else begin
          mon_e = exp_rd.pop_front();
          chk("rdata", rdata_o, mon_e);
          last_rd = mon_e;
        end
      end else begin
        chk("rdata_hold", rdata_o, last_rd);
      end
      rd_due = re_i;
      if (tx_en_o) begin
        chk("tx_en_while_busy", 32'(tx_busy_i), 32'h0);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_en_unexpected: got byte %h expected no issue", tx_data_o);
        end else begin
          chk("tx_data", 32'(tx_data_o), 32'(exp_tx.pop_front()));
        end
      end
      if (irq_known_cur) chk("irq", 32'(irq_o), 32'(irq_cur));
    end
  end

  initial begin
    do_reset();
    rd(4'h4);
    idle(2);

    // three bytes through a transmitter that stays busy for 10 cycles
    busy_min = 10; busy_max = 10;
    wr(4'h0, 32'h41); wr(4'h0, 32'h42); wr(4'h0, 32'h43);
    rd(4'h4);
    drain();
    rd(4'h4);

    // overflow the TX FIFO while the transmitter is held busy
    idle(5);
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) wr(4'h0, 32'(8'h60 + i));
    rd(4'h4);
    rd(4'h4);
    hold_busy = 1'b0;
    drain();

    // long rx_ready level gives a single push
    rx_lvl = 1'b1; rx_byte = 8'h5A;
    idle(50);
    rx_lvl = 1'b0;
    idle(2);
    rd(4'h4); rd(4'h0); rd(4'h0);

    // fill RX, then push and pop in the same cycle, then overrun
    for (int i = 0; i < 16; i++) begin
      rx_lvl = 1'b1; rx_byte = 8'(8'h10 + i); idle(1);
      rx_lvl = 1'b0; idle(1);
    end
    rd(4'h4);
    rx_lvl = 1'b1; rx_byte = 8'h99;
    rd(4'h0);
    rx_lvl = 1'b0;
    idle(1);
    rd(4'h4);
    rx_lvl = 1'b1; rx_byte = 8'h77; idle(1);
    rx_lvl = 1'b0; idle(1);
    rd(4'h4);
    for (int i = 0; i < 17; i++) rd(4'h0);

    // rx interrupt
    wr(4'h8, 32'h1);
    idle(2);
    rx_lvl = 1'b1; rx_byte = 8'hC3; idle(1);
    rx_lvl = 1'b0; idle(3);
    rd(4'h0);
    idle(3);

    // tx interrupt with an idle transmitter, then while bytes are in flight
    wr(4'h8, 32'h2);
    idle(5);
    wr(4'h0, 32'hA5);
    drain();
    wr(4'h8, 32'h0);
    rd(4'h8);

    // randomized traffic, reset mid-operation, more traffic
    busy_min = 1; busy_max = 10;
    rand_phase(500, 20);
    do_reset();
    rd(4'h4);
    idle(1);
    rand_phase(500, 3);
    drain();
    idle(3);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'h0);
    chk("tx_queue_empty", 32'(exp_tx.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
